// File: rtl/mdl_mlkem_modmul_pipe.sv
// ----------------------------------------------------------------------------
// mdl_mlkem_modmul_pipe
//
// Purpose: three-stage pipelined, multi-lane modular multiplier for the NTT
// datapath. Each lane computes (a*b [+ c]) mod PRM_Q with Barrett reduction.
// PRM_Q may be any odd modulus below 2^PRM_W.
//
// Optional feature macro: MLKEM_MODMUL_ACC_EN
//   defined     -> port iAcc exists and every lane computes (a*b + c) mod Q
//   not defined -> iAcc is absent and c is treated as 0
//
// Ports:
//   iClk       clock, all state changes on the rising edge
//   iRstn      asynchronous active-low reset
//   iValid     upstream operands valid
//   oSrcReady  block accepts operands this cycle
//   iSrc1      operand a, lane n in bits [n*W +: W]
//   iSrc2      operand b, same packing
//   iAcc       addend c, same packing (MLKEM_MODMUL_ACC_EN only)
//   iTag       sideband tag, carried unchanged alongside the data
//   oValid     result valid
//   iDstReady  downstream accepts the result
//   oDst       per-lane result, always in [0, Q)
//   oTag       tag of the transaction on oDst
//   oBusy      any stage holds a valid transaction
//
// Handshake: an input transfer happens on a rising edge where
// iValid && oSrcReady, an output transfer on a rising edge where
// oValid && iDstReady. The whole pipe moves as one unit:
// adv = !oValid || iDstReady. When adv is high every stage shifts by one
// (bubbles included); when low every stage holds, so oDst/oTag are stable
// during a stall. oSrcReady is adv itself, so an accept can happen in the
// same cycle iDstReady rises.
// ----------------------------------------------------------------------------
module mdl_mlkem_modmul_pipe #(
  parameter int          PRM_Q     = 3329,
  parameter int          PRM_W     = 12,
  parameter int          PRM_LANES = 2,
  parameter int          PRM_TAG_W = 8,
  parameter logic [63:0] PRM_MU    = (64'd1 << (2 * PRM_W)) / 64'(PRM_Q)
) (
  input  logic                       iClk,
  input  logic                       iRstn,
  input  logic                       iValid,
  output logic                       oSrcReady,
  input  logic [PRM_LANES*PRM_W-1:0] iSrc1,
  input  logic [PRM_LANES*PRM_W-1:0] iSrc2,
`ifdef MLKEM_MODMUL_ACC_EN
  input  logic [PRM_LANES*PRM_W-1:0] iAcc,
`endif
  input  logic [PRM_TAG_W-1:0]       iTag,
  output logic                       oValid,
  input  logic                       iDstReady,
  output logic [PRM_LANES*PRM_W-1:0] oDst,
  output logic [PRM_TAG_W-1:0]       oTag,
  output logic                       oBusy
);

  localparam int W  = PRM_W;
  localparam int L  = PRM_LANES;
  localparam int PW = 2 * PRM_W;   // product width
  localparam int RW = PRM_W + 2;   // Barrett remainder width, holds [0, 3Q)

  localparam logic [PW-1:0] MU  = PW'(PRM_MU);
  localparam logic [PW-1:0] Q_P = PW'(PRM_Q);
  localparam logic [RW-1:0] Q_1 = RW'(PRM_Q);
  localparam logic [RW-1:0] Q_2 = RW'(2 * PRM_Q);

  // --------------------------------------------------------------------------
  // Addend source
  // --------------------------------------------------------------------------
  logic [L*W-1:0] acc_term;
`ifdef MLKEM_MODMUL_ACC_EN
  assign acc_term = iAcc;
`else
  assign acc_term = '0;
`endif

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic           s1_v, s2_v, s3_v;
  logic [PRM_TAG_W-1:0] s1_tag, s2_tag, s3_tag;
  logic [PW-1:0]  s1_p [L];
  logic [PW-1:0]  s2_p [L];
  logic [PW-1:0]  s2_t [L];
  logic [L*W-1:0] s3_dst;

  // Next-stage values
  logic [PW-1:0]  p_d   [L];
  logic [PW-1:0]  t_d   [L];
  logic [RW-1:0]  r_raw [L];
  logic [W-1:0]   r_d   [L];

  logic adv;

  assign adv       = !s3_v || iDstReady;
  assign oSrcReady = adv;
  assign oValid    = s3_v;
  assign oDst      = s3_dst;
  assign oTag      = s3_tag;
  assign oBusy     = s1_v || s2_v || s3_v;

  // --------------------------------------------------------------------------
  // Per-lane arithmetic
  //   S1: p = a*b (+c); max value 2^2W - 2^W, so it fits in 2W bits.
  //   S2: t = (p*MU) >> 2W, the Barrett quotient estimate, short by <= 2.
  //   S3: r = p - t*Q lies in [0, 3Q). The subtraction is done modulo 2^2W
  //       and truncated to W+2 bits; since the true value is non-negative
  //       and below 3Q < 2^(W+2), the truncation is exact. Two conditional
  //       subtracts bring r into [0, Q).
  // --------------------------------------------------------------------------
  always_comb begin
    for (int l = 0; l < L; l++) begin
      p_d[l]   = PW'(iSrc1[l*W +: W]) * PW'(iSrc2[l*W +: W])
               + PW'(acc_term[l*W +: W]);
      t_d[l]   = PW'(({{PW{1'b0}}, s1_p[l]} * {{PW{1'b0}}, MU}) >> PW);
      r_raw[l] = RW'(s2_p[l] - s2_t[l] * Q_P);
      if (r_raw[l] >= Q_2) begin
        r_d[l] = W'(r_raw[l] - Q_2);
      end else if (r_raw[l] >= Q_1) begin
        r_d[l] = W'(r_raw[l] - Q_1);
      end else begin
        r_d[l] = W'(r_raw[l]);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage registers: all stages move together on adv. Data registers load
  // even when the incoming valid is 0; the valid bit alone qualifies them.
  // --------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s3_v   <= 1'b0;
      s1_tag <= '0;
      s2_tag <= '0;
      s3_tag <= '0;
      s3_dst <= '0;
      for (int l = 0; l < L; l++) begin
        s1_p[l] <= '0;
        s2_p[l] <= '0;
        s2_t[l] <= '0;
      end
    end else if (adv) begin
      s1_v   <= iValid;
      s2_v   <= s1_v;
      s3_v   <= s2_v;
      s1_tag <= iTag;
      s2_tag <= s1_tag;
      s3_tag <= s2_tag;
      for (int l = 0; l < L; l++) begin
        s1_p[l]            <= p_d[l];
        s2_p[l]            <= s1_p[l];
        s2_t[l]            <= t_d[l];
        s3_dst[l*W +: W]   <= r_d[l];
      end
    end
  end

endmodule

// File: tb/tb_mdl_mlkem_modmul_pipe.sv
// ----------------------------------------------------------------------------
// tb_mdl_mlkem_modmul_pipe
//
// Bench for mdl_mlkem_modmul_pipe. Two instances: the default ML-KEM
// configuration (Q=3329, W=12, two lanes) and an ML-DSA configuration
// (Q=8380417, W=23, one lane). Expected results come from plain modular
// arithmetic ((a*b + c) % Q) and are queued at accept time; a monitor pops
// and compares whenever an output transfer is about to happen.
// Build with +define+MLKEM_MODMUL_ACC_EN to exercise the accumulate variant.
// ----------------------------------------------------------------------------
module tb_mdl_mlkem_modmul_pipe;

  localparam int Q  = 3329;
  localparam int W  = 12;
  localparam int L  = 2;
  localparam int TW = 8;
  localparam int DQ = 8380417;
  localparam int DW = 23;

`ifdef MLKEM_MODMUL_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance signals
  logic           valid, src_ready, dst_ready, out_valid, busy;
  logic [L*W-1:0] src1, src2, dst;
  logic [TW-1:0]  tag_in, tag_out;
`ifdef MLKEM_MODMUL_ACC_EN
  logic [L*W-1:0] acc;
`endif

  // ML-DSA instance signals
  logic           d_valid, d_src_ready, d_out_valid, d_busy;
  logic [DW-1:0]  d_src1, d_src2, d_dst;
  logic [TW-1:0]  d_tag_in, d_tag_out;
`ifdef MLKEM_MODMUL_ACC_EN
  logic [DW-1:0]  d_acc;
`endif

  mdl_mlkem_modmul_pipe dut (
    .iClk      (clk),
    .iRstn     (rst_n),
    .iValid    (valid),
    .oSrcReady (src_ready),
    .iSrc1     (src1),
    .iSrc2     (src2),
`ifdef MLKEM_MODMUL_ACC_EN
    .iAcc      (acc),
`endif
    .iTag      (tag_in),
    .oValid    (out_valid),
    .iDstReady (dst_ready),
    .oDst      (dst),
    .oTag      (tag_out),
    .oBusy     (busy)
  );

  mdl_mlkem_modmul_pipe #(
    .PRM_Q     (DQ),
    .PRM_W     (DW),
    .PRM_LANES (1),
    .PRM_TAG_W (TW)
  ) dut_dsa (
    .iClk      (clk),
    .iRstn     (rst_n),
    .iValid    (d_valid),
    .oSrcReady (d_src_ready),
    .iSrc1     (d_src1),
    .iSrc2     (d_src2),
`ifdef MLKEM_MODMUL_ACC_EN
    .iAcc      (d_acc),
`endif
    .iTag      (d_tag_in),
    .oValid    (d_out_valid),
    .iDstReady (1'b1),
    .oDst      (d_dst),
    .oTag      (d_tag_out),
    .oBusy     (d_busy)
  );

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

  logic [L*W+TW-1:0] exp_q[$];
  logic [DW+TW-1:0]  exp_d_q[$];

  function automatic longint unsigned ref_mod(input longint unsigned a,
                                              input longint unsigned b,
                                              input longint unsigned c,
                                              input longint unsigned q);
    return (a * b + c) % q;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return W'(Q - 1);
      2:       return W'(Q);
      3:       return {W{1'b1}};
      default: return W'($urandom_range(0, (1 << W) - 1));
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic send(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                      input logic [L*W-1:0] c, input logic [TW-1:0] t);
    logic [L*W-1:0] e;
    int n;
    @(negedge clk);
    src1   = a;
    src2   = b;
    tag_in = t;
    valid  = 1'b1;
`ifdef MLKEM_MODMUL_ACC_EN
    acc    = c;
`endif
    #1;
    n = 0;
    while (!src_ready && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!src_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=not_ready required=ready");
      valid = 1'b0;
      return;
    end
    for (int l = 0; l < L; l++) begin
      e[l*W +: W] = W'(ref_mod(a[l*W +: W], b[l*W +: W],
                               ACC_EN ? 64'(c[l*W +: W]) : 64'd0, Q));
    end
    exp_q.push_back({t, e});
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic send_d(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [TW-1:0] t);
    @(negedge clk);
    d_src1   = a;
    d_src2   = b;
    d_tag_in = t;
    d_valid  = 1'b1;
`ifdef MLKEM_MODMUL_ACC_EN
    d_acc    = c;
`endif
    #1;
    check("dsa_src_ready", d_src_ready, 1);
    exp_d_q.push_back({t, DW'(ref_mod(a, b, ACC_EN ? 64'(c) : 64'd0, DQ))});
    @(posedge clk);
    #1 d_valid = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Downstream ready pattern
  // --------------------------------------------------------------------------
  initial begin : ready_drv
    dst_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       dst_ready = 1'b1;
        1:       dst_ready = ($urandom_range(0, 2) != 0);
        default: dst_ready = 1'b0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: sampled mid-cycle; a transfer happens at the next rising edge
  // when oValid && iDstReady. A stalled output must not change.
  // --------------------------------------------------------------------------
  initial begin : monitor
    logic           hold_v;
    logic [L*W-1:0] hold_dst;
    logic [TW-1:0]  hold_tag;
    logic [L*W+TW-1:0] e;
    logic [DW+TW-1:0]  ed;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("stall_valid", out_valid, 1);
          check("stall_dst", dst, hold_dst);
          check("stall_tag", tag_out, hold_tag);
        end
        if (out_valid && dst_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output actual=%0h required=none", dst);
          end else begin
            e = exp_q.pop_front();
            check("dst", dst, e[L*W-1:0]);
            check("tag", tag_out, e[L*W +: TW]);
            for (int l = 0; l < L; l++) begin
              check("dst_lt_q", dst[l*W +: W] < W'(Q), 1);
            end
          end
        end
        hold_v   = out_valid && !dst_ready;
        hold_dst = dst;
        hold_tag = tag_out;

        if (d_out_valid) begin
          if (exp_d_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL dsa_unexpected_output actual=%0d required=none", d_dst);
          end else begin
            ed = exp_d_q.pop_front();
            check("dsa_dst", d_dst, ed[DW-1:0]);
            check("dsa_tag", d_tag_out, ed[DW +: TW]);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
  initial begin : watchdog
    #900000;
    total++;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin : main
    int n;
    rst_n    = 1'b0;
    valid    = 1'b0;
    src1     = '0;
    src2     = '0;
    tag_in   = '0;
    d_valid  = 1'b0;
    d_src1   = '0;
    d_src2   = '0;
    d_tag_in = '0;
`ifdef MLKEM_MODMUL_ACC_EN
    acc      = '0;
    d_acc    = '0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_dst", dst, 0);
    check("rst_tag", tag_out, 0);
    check("rst_busy", busy, 0);
    check("rst_src_ready", src_ready, 1);
    check("rst_dsa_valid", d_out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed values and latency: visible after the third rising edge
    // counting the accepting one.
    ready_mode = 0;
    send({12'd1234, 12'd3328}, {12'd2345, 12'd3328}, '0, 8'h5A);
    @(negedge clk); #3;
    check("lat_1_valid", out_valid, 0);
    check("lat_1_busy", busy, 1);
    @(negedge clk); #3;
    check("lat_2_valid", out_valid, 0);
    @(negedge clk); #3;
    check("lat_3_valid", out_valid, 1);
    check("dir0_lane0", dst[11:0], 1);
    check("dir0_lane1", dst[23:12], 829);
    check("dir0_tag", tag_out, 8'h5A);

    send({12'd0, 12'd4095}, {12'd3000, 12'd4095}, '0, 8'hA5);
    repeat (3) @(negedge clk);
    #3;
    check("dir1_valid", out_valid, 1);
    check("dir1_lane0", dst[11:0], 852);
    check("dir1_lane1", dst[23:12], 0);

`ifdef MLKEM_MODMUL_ACC_EN
    send({12'd4095, 12'd3328}, {12'd4095, 12'd3328}, {12'd4095, 12'd3328}, 8'h3C);
    repeat (3) @(negedge clk);
    #3;
    check("acc_lane0", dst[11:0], 0);
    check("acc_lane1", dst[23:12], 1618);
`endif

    // Back-to-back with a toggling downstream ready
    ready_mode = 1;
    for (int i = 0; i < 16; i++) begin
      send({rand_op(), rand_op()}, {rand_op(), rand_op()},
           {rand_op(), rand_op()}, TW'(i));
    end

    // Randomized sweep
    for (int i = 0; i < 2000; i++) begin
      send({rand_op(), rand_op()}, {rand_op(), rand_op()},
           {rand_op(), rand_op()}, TW'($urandom_range(0, 255)));
    end

    ready_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);

    // Reset with three transactions in flight
    ready_mode = 2;
    repeat (2) @(negedge clk);
    send(24'h111222, 24'h333444, '0, 8'h01);
    send(24'h555666, 24'h777888, '0, 8'h02);
    send(24'h999AAA, 24'hBBBCCC, '0, 8'h03);
    @(negedge clk); #1;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dst", dst, 0);
    check("mid_rst_src_ready", src_ready, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #3;
      check("post_rst_valid", out_valid, 0);
      check("post_rst_busy", busy, 0);
    end
    send({12'd1, 12'd2}, {12'd3, 12'd4}, {12'd5, 12'd6}, 8'h77);
    send({12'd3328, 12'd100}, {12'd3328, 12'd200}, '0, 8'h78);

    // ML-DSA configuration
    send_d(23'd8380416, 23'd8380416, '0, 8'hD0);
    repeat (3) @(negedge clk);
    #3;
    check("dsa_dir0_valid", d_out_valid, 1);
    check("dsa_dir0_dst", d_dst, 1);
    send_d({DW{1'b1}}, {DW{1'b1}}, '0, 8'hD1);
    send_d({DW{1'b1}}, {DW{1'b1}}, {DW{1'b1}}, 8'hD2);
    for (int i = 0; i < 40; i++) begin
      send_d(DW'($urandom_range(0, (1 << DW) - 1)),
             DW'($urandom_range(0, (1 << DW) - 1)),
             DW'($urandom_range(0, (1 << DW) - 1)), TW'(i));
    end

    n = 0;
    while ((exp_q.size() != 0 || exp_d_q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("final_drain", exp_q.size() + exp_d_q.size(), 0);
    @(negedge clk); #3;
    check("final_busy", busy, 0);
    check("final_dsa_busy", d_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
